mul8_sequencer: RTL and testbench

MUL8_SEQUENCER -- requirements
Module: mul8_sequencer

---
 rtl/mul8_sequencer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_mul8_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul8_sequencer.sv
// mul8_sequencer: 8x8 multiply built from four 4x4 partial products taken
// from an external shared 4x4 multiplier, one nibble pair per cycle.
//
// Sequence: IDLE/DONE --accept--> LL -> LH -> HL -> HH -> DONE.
// mul_x/mul_y select the nibble pair for the current state, mul_p comes back
// combinationally and is added into a 16-bit accumulator at the step edge,
// shifted into place. product is loaded on the HH->DONE edge and held.
//
// Configuration:
//   MUL8_SIGNED_EN  - when defined, a, b and product are two's complement.
//                     Operand magnitudes are multiplied and the result is
//                     negated on the final edge when the operand signs differ.
//                     When undefined, the block is unsigned only.
//
// All outputs are registered: mul_x/mul_y/busy/done are computed from the
// next state and next operands so they line up with the state register.
// ena=0 freezes every register, including a done that is already high.

module mul8_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [3:0]  mul_x,
  output logic [3:0]  mul_y,
  input  logic [7:0]  mul_p,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LL   = 3'd1,
    LH   = 3'd2,
    HL   = 3'd3,
    HH   = 3'd4,
    DONE = 3'd5
  } state_t;

  // Nibble pair {x, y} presented to the shared multiplier in a given state.
  function automatic logic [7:0] nib_sel(input state_t st,
                                         input logic [7:0] av,
                                         input logic [7:0] bv);
    logic [7:0] sel;
    case (st)
      LL:      sel = {av[3:0], bv[3:0]};
      LH:      sel = {av[3:0], bv[7:4]};
      HL:      sel = {av[7:4], bv[3:0]};
      HH:      sel = {av[7:4], bv[7:4]};
      default: sel = 8'h00;
    endcase
    return sel;
  endfunction

`ifdef MUL8_SIGNED_EN
  // Magnitude of an 8-bit two's complement value; -128 maps to 8'h80,
  // which is correct when the result is read as unsigned.
  function automatic logic [7:0] mag8(input logic [7:0] v);
    logic [7:0] m;
    if (v[7] == 1'b1) begin
      m = 8'h00 - v;
    end else begin
      m = v;
    end
    return m;
  endfunction
`endif

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic [7:0]  a_s;
  logic [7:0]  b_s;
  logic [15:0] acc_r;
  logic [15:0] acc_s;
  logic [15:0] product_r;
  logic [15:0] product_s;
  logic [3:0]  mul_x_r;
  logic [3:0]  mul_y_r;
  logic        busy_r;
  logic        done_r;
  logic        accept_s;
  logic        step_s;
  logic [15:0] addend_s;
  logic [15:0] sum_s;
  logic [15:0] final_s;
  logic [7:0]  nib_s;
  logic [7:0]  a_load_s;
  logic [7:0]  b_load_s;
`ifdef MUL8_SIGNED_EN
  logic        sign_r;
  logic        sign_s;
`endif

  // Accept only while enabled and in a state that can take a new operation.
  always_comb begin
    accept_s = 1'b0;
    step_s   = 1'b0;
    if ((ena == 1'b1) && (start == 1'b1) &&
        ((state_r == IDLE) || (state_r == DONE))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if ((state_r == LL) || (state_r == LH) ||
        (state_r == HL) || (state_r == HH)) begin
      step_s = 1'b1;
    end else begin
      step_s = 1'b0;
    end
  end

  // Next-state logic; ena=0 holds the current state.
  always_comb begin
    state_s = state_r;
    if (ena == 1'b1) begin
      case (state_r)
        IDLE: begin
          if (start == 1'b1) begin
            state_s = LL;
          end else begin
            state_s = IDLE;
          end
        end
        LL:   state_s = LH;
        LH:   state_s = HL;
        HL:   state_s = HH;
        HH:   state_s = DONE;
        DONE: begin
          if (start == 1'b1) begin
            state_s = LL;
          end else begin
            state_s = IDLE;
          end
        end
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Operand values stored on accept (magnitudes in the signed build).
  always_comb begin
`ifdef MUL8_SIGNED_EN
    a_load_s = mag8(a);
    b_load_s = mag8(b);
`else
    a_load_s = a;
    b_load_s = b;
`endif
  end

  // Operand latches: loaded on accept, otherwise held (start ignored mid-op).
  always_comb begin
    a_s = a_r;
    b_s = b_r;
    if (accept_s == 1'b1) begin
      a_s = a_load_s;
      b_s = b_load_s;
    end else begin
      a_s = a_r;
      b_s = b_r;
    end
  end

`ifdef MUL8_SIGNED_EN
  // Result sign captured alongside the operands.
  always_comb begin
    sign_s = sign_r;
    if (accept_s == 1'b1) begin
      sign_s = a[7] ^ b[7];
    end else begin
      sign_s = sign_r;
    end
  end
`endif

  // Partial product aligned to its nibble weight, and the running sum.
  always_comb begin
    addend_s = 16'h0000;
    case (state_r)
      LL:      addend_s = {8'h00, mul_p};
      LH:      addend_s = {4'h0, mul_p, 4'h0};
      HL:      addend_s = {4'h0, mul_p, 4'h0};
      HH:      addend_s = {mul_p, 8'h00};
      default: addend_s = 16'h0000;
    endcase
    sum_s = acc_r + addend_s;
  end

  // Final result, negated in the signed build when the operand signs differ.
  always_comb begin
    final_s = sum_s;
`ifdef MUL8_SIGNED_EN
    if (sign_r == 1'b1) begin
      final_s = 16'h0000 - sum_s;
    end else begin
      final_s = sum_s;
    end
`endif
  end

  // Accumulator and product register updates, gated by ena.
  always_comb begin
    acc_s     = acc_r;
    product_s = product_r;
    if (ena == 1'b1) begin
      if (accept_s == 1'b1) begin
        acc_s = 16'h0000;
      end else if (step_s == 1'b1) begin
        acc_s = sum_s;
      end else begin
        acc_s = acc_r;
      end
      if (state_r == HH) begin
        product_s = final_s;
      end else begin
        product_s = product_r;
      end
    end else begin
      acc_s     = acc_r;
      product_s = product_r;
    end
  end

  // Nibble pair for the state being entered, from the operands being stored.
  always_comb begin
    nib_s = nib_sel(state_s, a_s, b_s);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      a_r       <= 8'h00;
      b_r       <= 8'h00;
      acc_r     <= 16'h0000;
      product_r <= 16'h0000;
      mul_x_r   <= 4'h0;
      mul_y_r   <= 4'h0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      a_r       <= a_s;
      b_r       <= b_s;
      acc_r     <= acc_s;
      product_r <= product_s;
      mul_x_r   <= nib_s[7:4];
      mul_y_r   <= nib_s[3:0];
      busy_r    <= (state_s == LL) || (state_s == LH) ||
                   (state_s == HL) || (state_s == HH);
      done_r    <= (state_s == DONE);
    end
  end

`ifdef MUL8_SIGNED_EN
  // Result sign register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r <= 1'b0;
    end else begin
      sign_r <= sign_s;
    end
  end
`endif

  assign mul_x   = mul_x_r;
  assign mul_y   = mul_y_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_mul8_sequencer.sv
// Directed bench for mul8_sequencer with a behavioural 4x4 shared multiplier.
// Inputs are driven and outputs sampled 1 ns after the rising edge.

module tb_mul8_sequencer;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  mul_x;
  logic [3:0]  mul_y;
  logic [7:0]  mul_p;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_checks;
  int n_errors;

  mul8_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .start   (start),
    .a       (a),
    .b       (b),
    .mul_x   (mul_x),
    .mul_y   (mul_y),
    .mul_p   (mul_p),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Shared 4x4 multiplier.
  assign mul_p = {4'h0, mul_x} * {4'h0, mul_y};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (got running, need finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check busy/done/mul_x/mul_y together.
  task automatic check_ctl(input string tag, input logic bz, input logic dn,
                           input logic [3:0] x, input logic [3:0] y);
    check({tag, "_busy"}, 16'(busy), 16'(bz));
    check({tag, "_done"}, 16'(done), 16'(dn));
    check({tag, "_mx"}, 16'(mul_x), 16'(x));
    check({tag, "_my"}, 16'(mul_y), 16'(y));
  endtask

  // Start one multiply, wait (bounded) for done, check latency and product.
  task automatic run_mul(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [15:0] exp);
    int n;
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    check({tag, "_busy"}, 16'(busy), 16'd1);
    n = 0;
    while ((done !== 1'b1) && (n < 20)) begin
      tick();
      n = n + 1;
    end
    check({tag, "_lat"}, 16'(n), 16'd4);
    check({tag, "_prod"}, product, exp);
    tick();
    check({tag, "_done_drop"}, 16'(done), 16'd0);
    check({tag, "_hold"}, product, exp);
  endtask

  initial begin
    int n;
    logic saw_done;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    ena   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;

    // Reset state, before any clock edge.
    #3;
    check_ctl("rst", 1'b0, 1'b0, 4'h0, 4'h0);
    check("rst_prod", product, 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_ctl("idle", 1'b0, 1'b0, 4'h0, 4'h0);

    // 13 * 11: step-by-step nibble sequence.
    a = 8'd13;
    b = 8'd11;
    start = 1'b1;
    tick();                 // E0
    start = 1'b0;
    check_ctl("s13_ll", 1'b1, 1'b0, 4'hD, 4'hB);
    tick();                 // E1
    check_ctl("s13_lh", 1'b1, 1'b0, 4'hD, 4'h0);
    tick();                 // E2
    check_ctl("s13_hl", 1'b1, 1'b0, 4'h0, 4'hB);
    tick();                 // E3
    check_ctl("s13_hh", 1'b1, 1'b0, 4'h0, 4'h0);
    tick();                 // E4
    check_ctl("s13_done", 1'b0, 1'b1, 4'h0, 4'h0);
    check("s13_prod", product, 16'h008F);
    tick();                 // E5
    check_ctl("s13_idle", 1'b0, 1'b0, 4'h0, 4'h0);
    check("s13_hold", product, 16'h008F);

    // Nibble sequence with non-zero high nibbles: 0x5A * 0xC3.
    a = 8'h5A;
    b = 8'hC3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_ctl("n5a_ll", 1'b1, 1'b0, 4'hA, 4'h3);
    tick();
    check_ctl("n5a_lh", 1'b1, 1'b0, 4'hA, 4'hC);
    tick();
    check_ctl("n5a_hl", 1'b1, 1'b0, 4'h5, 4'h3);
    tick();
    check_ctl("n5a_hh", 1'b1, 1'b0, 4'h5, 4'hC);
    tick();
`ifdef MUL8_SIGNED_EN
    // 90 * -61 = -5490
    check("n5a_prod", product, 16'hEA8E);
`else
    // 90 * 195 = 17550
    check("n5a_prod", product, 16'h448E);
`endif
    tick();

`ifndef MUL8_SIGNED_EN
    run_mul("ffff", 8'hFF, 8'hFF, 16'hFE01);
`endif

    // Start during an operation is ignored; start held into DONE is accepted.
    a = 8'd2;
    b = 8'd3;
    start = 1'b1;
    tick();                 // E0
    start = 1'b0;
    tick();                 // E1 -> LH
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    tick();                 // E2 (ignored)
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    check_ctl("ign_hl", 1'b1, 1'b0, 4'h0, 4'h3);
    tick();                 // E3
    tick();                 // E4
    check("ign_done", 16'(done), 16'd1);
    check("ign_prod", product, 16'h0006);
    a = 8'd4;
    b = 8'd5;
    start = 1'b1;
    tick();                 // E5: accept from DONE
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    check_ctl("b2b_ll", 1'b1, 1'b0, 4'h4, 4'h5);
    tick();
    tick();
    tick();
    tick();
    check("b2b_done", 16'(done), 16'd1);
    check("b2b_prod", product, 16'h0014);
    tick();

    // Freeze for 3 cycles while in LH.
    a = 8'd7;
    b = 8'd7;
    start = 1'b1;
    tick();                 // E0
    start = 1'b0;
    tick();                 // E1 -> LH
    ena = 1'b0;
    tick();
    tick();
    tick();
    check_ctl("frz_lh", 1'b1, 1'b0, 4'h7, 4'h0);
    check("frz_prod", product, 16'h0014);
    ena = 1'b1;
    n = 0;
    while ((done !== 1'b1) && (n < 20)) begin
      tick();
      n = n + 1;
    end
    check("frz_lat", 16'(n), 16'd3);
    check("frz_result", product, 16'h0031);
    // Done held while frozen; start not sampled.
    ena = 1'b0;
    start = 1'b1;
    a = 8'd1;
    b = 8'd1;
    tick();
    tick();
    check_ctl("frz_done", 1'b0, 1'b1, 4'h0, 4'h0);
    start = 1'b0;
    ena = 1'b1;
    tick();
    check_ctl("frz_idle", 1'b0, 1'b0, 4'h0, 4'h0);
    check("frz_hold", product, 16'h0031);

    // Reset mid-operation.
    a = 8'h55;
    b = 8'h33;
    start = 1'b1;
    tick();                 // E0
    start = 1'b0;
    tick();                 // E1
    #2;
    rst_n = 1'b0;
    #1;
    check_ctl("mrst", 1'b0, 1'b0, 4'h0, 4'h0);
    check("mrst_prod", product, 16'h0000);
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("mrst_no_done", 16'(saw_done), 16'd0);
    check("mrst_idle_busy", 16'(busy), 16'd0);
    run_mul("p55", 8'h55, 8'h33, 16'h10EF);

`ifdef MUL8_SIGNED_EN
    run_mul("sneg", 8'hFD, 8'h05, 16'hFFF1);
    run_mul("smin", 8'h80, 8'h80, 16'h4000);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
